// File: rtl/mult_seq.sv
// mult_seq: HI/LO owner and sequencer for the external 32x32 multiplier.
// Magnitude operands in, sign-corrected 64-bit product out.
module mult_seq #(
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        cancel,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  input  logic [63:0] mul_z,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [1:0] OP_MULTU = 2'b00;
  localparam logic [1:0] OP_MULT  = 2'b01;
  localparam logic [1:0] OP_MTHI  = 2'b10;
  localparam logic [1:0] OP_MTLO  = 2'b11;

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic {IDLE, MUL} state_t;

  state_t      state;
  state_t      state_nx;
  logic [3:0]  cnt;
  logic        neg;
  logic        accept;
  logic        mul_go;
  logic        finish;
  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic [63:0] prod;

  assign accept = (state == IDLE) && start && !cancel;
  assign mul_go = accept && !op[1];
  assign finish = (state == MUL) && (cnt == 4'd0) && !cancel;
  assign busy   = (state == MUL);

  assign abs_a = rs_data[31] ? (~rs_data + 32'd1) : rs_data;
  assign abs_b = rt_data[31] ? (~rt_data + 32'd1) : rt_data;
  assign prod  = neg ? (~mul_z + 64'd1) : mul_z;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next state: enter MUL on a multiply, leave on cancel or last cycle
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (mul_go) state_nx = MUL;
      MUL:  if (cancel || cnt == 4'd0) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Settle counter, loaded on accept and run down while in MUL
  always_ff @(posedge clk) begin
    if (rst)                          cnt <= 4'd0;
    else if (mul_go)                  cnt <= CNT_INIT;
    else if (busy && cnt != 4'd0)     cnt <= cnt - 4'd1;
  end

  // Operand and sign capture, only on a multiply accept
  always_ff @(posedge clk) begin
    if (rst) begin
      mul_a <= 32'd0;
      mul_b <= 32'd0;
      neg   <= 1'b0;
    end else if (mul_go) begin
      if (op == OP_MULT) begin
        mul_a <= abs_a;
        mul_b <= abs_b;
        neg   <= rs_data[31] ^ rt_data[31];
      end else begin
        mul_a <= rs_data;
        mul_b <= rt_data;
        neg   <= 1'b0;
      end
    end
  end

  // HI/LO: product write on finish, direct moves on MTHI/MTLO
  always_ff @(posedge clk) begin
    if (rst) begin
      hi <= 32'd0;
      lo <= 32'd0;
    end else if (finish) begin
      hi <= prod[63:32];
      lo <= prod[31:0];
    end else if (accept && op == OP_MTHI) begin
      hi <= rs_data;
    end else if (accept && op == OP_MTLO) begin
      lo <= rs_data;
    end
  end

  // One-cycle completion pulse
  always_ff @(posedge clk) begin
    if (rst) done <= 1'b0;
    else     done <= finish;
  end

  logic unused_op;
  assign unused_op = (OP_MULTU == 2'b00);

endmodule

// File: tb/tb_mult_seq.sv
// tb_mult_seq: directed stimulus, cycle model with signed arithmetic,
// per-cycle compare plus literal pins.
module tb_mult_seq;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        cancel;
  logic [31:0] mul_a;
  logic [31:0] mul_b;
  logic [63:0] mul_z;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_assert = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  always #5 clk = ~clk;

  assign mul_z = {32'd0, mul_a} * {32'd0, mul_b};

  mult_seq #(.LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op),
    .rs_data(rs_data), .rt_data(rt_data), .cancel(cancel),
    .mul_a(mul_a), .mul_b(mul_b), .mul_z(mul_z),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  // Reference model: remaining-cycles count and a precomputed result
  int          m_rem;
  logic [63:0] m_res;
  logic [31:0] m_hi, m_lo, m_ma, m_mb;
  logic        m_done;

  function automatic logic [31:0] mag(input logic [31:0] v);
    longint a;
    a = longint'($signed(v));
    if (a < 0) a = -a;
    return a[31:0];
  endfunction

  function automatic logic [63:0] smul(input logic [31:0] a,
                                       input logic [31:0] b);
    longint p;
    p = longint'($signed(a)) * longint'($signed(b));
    return p;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_rem <= 0; m_res <= '0; m_hi <= '0; m_lo <= '0;
      m_ma <= '0; m_mb <= '0; m_done <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (m_rem > 0) begin
        if (cancel) m_rem <= 0;
        else if (m_rem == 1) begin
          m_rem <= 0;
          m_hi <= m_res[63:32];
          m_lo <= m_res[31:0];
          m_done <= 1'b1;
        end else m_rem <= m_rem - 1;
      end else if (start && !cancel) begin
        case (op)
          2'b00: begin
            m_res <= {32'd0, rs_data} * {32'd0, rt_data};
            m_ma <= rs_data; m_mb <= rt_data; m_rem <= LAT;
          end
          2'b01: begin
            m_res <= smul(rs_data, rt_data);
            m_ma <= mag(rs_data); m_mb <= mag(rt_data); m_rem <= LAT;
          end
          2'b10: m_hi <= rs_data;
          default: m_lo <= rs_data;
        endcase
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model
  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", 64'(busy), 64'(m_rem > 0));
      check("done", 64'(done), 64'(m_done));
      check("hi", 64'(hi), 64'(m_hi));
      check("lo", 64'(lo), 64'(m_lo));
      check("mul_a", 64'(mul_a), 64'(m_ma));
      check("mul_b", 64'(mul_b), 64'(m_mb));
    end
  end

  task automatic drive(input logic [1:0] o, input logic [31:0] a,
                       input logic [31:0] b);
    start = 1'b1; op = o; rs_data = a; rt_data = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int nb);
    bit seen;
    nb = 0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (busy) nb++;
      @(negedge clk);
    end
    check("done_timeout", 64'(seen), 64'd1);
  endtask

  task automatic pin(input string name, input logic [31:0] eh,
                     input logic [31:0] el);
    check({name, "_hi"}, 64'(hi), 64'(eh));
    check({name, "_lo"}, 64'(lo), 64'(el));
    check({name, "_mhi"}, 64'(m_hi), 64'(eh));
    check({name, "_mlo"}, 64'(m_lo), 64'(el));
  endtask

  initial begin
    int nb;
    rst = 1'b1; start = 1'b0; op = 2'b00;
    rs_data = '0; rt_data = '0; cancel = 1'b0;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    pin("rst", 32'd0, 32'd0);
    check("rst_mul_a", 64'(mul_a), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    drive(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(nb);
    check("multu_busy_cycles", 64'(nb), 64'(LAT));
    pin("multu_ff", 32'hFFFF_FFFE, 32'h0000_0001);
    @(negedge clk);

    drive(2'b01, 32'hFFFF_FFFD, 32'd5);
    check("mult_m3_a", 64'(mul_a), 64'd3);
    check("mult_m3_b", 64'(mul_b), 64'd5);
    wait_done(nb);
    pin("mult_m3x5", 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    @(negedge clk);

    drive(2'b01, 32'h8000_0000, 32'h8000_0000);
    check("mult_min_a", 64'(mul_a), 64'h8000_0000);
    check("mult_min_b", 64'(mul_b), 64'h8000_0000);
    wait_done(nb);
    pin("mult_min", 32'h4000_0000, 32'd0);
    @(negedge clk);

    drive(2'b01, 32'hFFFF_FFFF, 32'd0);
    wait_done(nb);
    pin("mult_zero", 32'd0, 32'd0);
    @(negedge clk);

    start = 1'b1; op = 2'b10; rs_data = 32'h1234_5678;
    @(negedge clk);
    check("mthi_hi", 64'(hi), 64'h1234_5678);
    op = 2'b11; rs_data = 32'h9ABC_DEF0;
    @(negedge clk);
    start = 1'b0;
    pin("mtlo", 32'h1234_5678, 32'h9ABC_DEF0);
    @(negedge clk);

    drive(2'b00, 32'd7, 32'd6);
    start = 1'b1; op = 2'b10; rs_data = 32'hDEAD_BEEF;
    @(negedge clk);
    start = 1'b0; cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    check("cancel_busy", 64'(busy), 64'd0);
    check("cancel_done", 64'(done), 64'd0);
    pin("cancel", 32'h1234_5678, 32'h9ABC_DEF0);
    @(negedge clk);

    drive(2'b00, 32'd7, 32'd6);
    wait_done(nb);
    pin("multu_7x6", 32'd0, 32'd42);

    drive(2'b00, 32'd3, 32'd4);
    wait_done(nb);
    pin("b2b_3x4", 32'd0, 32'd12);
    drive(2'b01, 32'hFFFF_FFFE, 32'd3);
    wait_done(nb);
    pin("b2b_m2x3", 32'hFFFF_FFFF, 32'hFFFF_FFFA);

    drive(2'b00, 32'd9, 32'd9);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_busy", 64'(busy), 64'd0);
    pin("midrst", 32'd0, 32'd0);
    repeat (4) @(negedge clk);
    check("midrst_done", 64'(done), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
